// File: rtl/rr_arb_pkg.sv
// Shared definitions for the 4-way round-robin arbiter.
//   NUM_REQ   : number of requesters
//   SEL_W     : width of the binary mux select
//   state_e   : arbiter state (IDLE / OWN)
//   onehot2bin: one-hot grant to binary select encoder
package rr_arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_e;

  // OR-reduction encoder; input is expected to be one-hot or zero
  function automatic logic [SEL_W-1:0] onehot2bin(input logic [NUM_REQ-1:0] oh);
    logic [SEL_W-1:0] b;
    b = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) b = b | SEL_W'(i);
    end
    return b;
  endfunction

endpackage

// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between producers and the arbiter.
//   req   : level request, bit i = source i
//   lock  : owner tenure extension (only when RR_ARB_LOCK_EN is defined)
//   grant : registered one-hot grant, 0 when idle
//   sel   : binary index of grant for mux_4.sel
//   valid : grant is non-zero
// master = requester side, slave = arbiter side.
interface rr_arbiter_4_if;
  import rr_arb_pkg::*;

  logic [NUM_REQ-1:0] req;
`ifdef RR_ARB_LOCK_EN
  logic               lock;
`endif
  logic [NUM_REQ-1:0] grant;
  logic [SEL_W-1:0]   sel;
  logic               valid;

  modport master (
`ifdef RR_ARB_LOCK_EN
    output lock,
`endif
    output req,
    input  grant, sel, valid
  );

  modport slave (
`ifdef RR_ARB_LOCK_EN
    input  lock,
`endif
    input  req,
    output grant, sel, valid
  );

endinterface

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker.
//   req_i     : candidate requests
//   ptr_i     : highest-priority index; search runs ptr, ptr+1, ... mod 4
//   pick_c_o  : one-hot first candidate in search order (0 if none)
//   found_c_o : a candidate was found
module rr_pick4
  import rr_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [SEL_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] pick_c_o,
  output logic               found_c_o
);

  logic [SEL_W-1:0] idx;

  // First set bit walking up from ptr_i; index arithmetic wraps at 4
  always_comb begin
    pick_c_o  = '0;
    found_c_o = 1'b0;
    idx       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = ptr_i + SEL_W'(k);
      if (!found_c_o && req_i[idx]) begin
        pick_c_o[idx] = 1'b1;
        found_c_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with bounded tenure, driving mux_4.sel.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : rr_arbiter_4_if.slave (req in, grant/sel/valid out, lock in)
// Optional feature: define RR_ARB_LOCK_EN to add bus.lock, which suppresses
// HOLD_MAX preemption while the owner keeps requesting.
module rr_arbiter_4
  import rr_arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 4
)
(
  input  logic              clk,
  input  logic              rst_n,
  rr_arbiter_4_if.slave     bus
);

  localparam int unsigned CNT_W = 4;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [SEL_W-1:0]   sel_q;
  logic               valid_q;

  logic [SEL_W-1:0]   owner_idx;
  logic [NUM_REQ-1:0] others;
  logic [SEL_W-1:0]   ho_ptr;
  logic [NUM_REQ-1:0] idle_pick, ho_pick;
  logic               idle_found, ho_found;
  logic               at_max, lock_hold, release_c;

  assign owner_idx = onehot2bin(grant_q);
  // Owner is masked so it is considered last after its own release
  assign others    = bus.req & ~grant_q;
  assign ho_ptr    = owner_idx + SEL_W'(1);
  assign at_max    = (cnt_q == CNT_W'(HOLD_MAX));

`ifdef RR_ARB_LOCK_EN
  assign lock_hold = bus.lock;
`else
  assign lock_hold = 1'b0;
`endif

  assign release_c = !bus.req[owner_idx] || (at_max && (|others) && !lock_hold);

  // Fresh arbitration from IDLE
  rr_pick4 u_pick_idle (
    .req_i     (bus.req),
    .ptr_i     (ptr_q),
    .pick_c_o  (idle_pick),
    .found_c_o (idle_found)
  );

  // Same-edge handover search starting just past the current owner
  rr_pick4 u_pick_ho (
    .req_i     (others),
    .ptr_i     (ho_ptr),
    .pick_c_o  (ho_pick),
    .found_c_o (ho_found)
  );

  // Next-state logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (idle_found) begin
          grant_d = idle_pick;
          cnt_d   = CNT_W'(1);
          state_d = OWN;
        end
      end
      OWN: begin
        if (release_c) begin
          ptr_d = ho_ptr;
          if (ho_found) begin
            grant_d = ho_pick;
            cnt_d   = CNT_W'(1);
          end else begin
            grant_d = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end else if (!at_max) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; sel/valid derived from next grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      sel_q   <= onehot2bin(grant_d);
      valid_q <= |grant_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.sel   = sel_q;
  assign bus.valid = valid_q;

endmodule
